// File: rtl/memseq_if.sv
// memseq_if: player/display-side signal bundle of the memory-sequence engine.
//
// Handshake rule: there is no backpressure. An entry is consumed on a clk50
// rising edge exactly when entry_valid is high and await_input is high;
// entry_valid on any other edge is dropped. start is a one-cycle request
// that is acted on only while the engine is idle or finished. pass_p and
// fail_p are one-cycle result strobes.
//
// Signals:
//   start        engine <- player   begin a new game (pulse)
//   entry_valid  engine <- player   entry strobe (pulse)
//   entry        engine <- player   one-hot button entry
//   lights       engine -> display  one-hot playback, 0 when dark
//   await_input  engine -> display  entries currently accepted
//   level        engine -> display  current level, 0-based
//   score        engine -> display  completed levels, saturating at 15
//   lives_left   engine -> display  remaining lives
//   pass_p       engine -> display  level completed (pulse)
//   fail_p       engine -> display  wrong entry (pulse)
//   game_over    engine -> display  all lives lost
//   won          engine -> display  last level completed
interface memseq_if #(
    parameter int N_LIGHTS = 4
);
    logic                start;
    logic                entry_valid;
    logic [N_LIGHTS-1:0] entry;
    logic [N_LIGHTS-1:0] lights;
    logic                await_input;
    logic [7:0]          level;
    logic [3:0]          score;
    logic [2:0]          lives_left;
    logic                pass_p;
    logic                fail_p;
    logic                game_over;
    logic                won;

    modport slave (
        input  start, entry_valid, entry,
        output lights, await_input, level, score, lives_left,
               pass_p, fail_p, game_over, won
    );

    modport master (
        output start, entry_valid, entry,
        input  lights, await_input, level, score, lives_left,
               pass_p, fail_p, game_over, won
    );
endinterface

// File: rtl/memseq_engine.sv
// memseq_engine: memory-sequence game engine. Each level generates a
// pseudo-random sequence from a free-running LFSR, plays it out on one-hot
// lights with programmable on/off timing, then checks player entries step by
// step. Wrong entries cost a life and replay the same sequence; losing all
// lives or clearing the last level ends the game.
//
// Ports:
//   clk50      in   system clock, rising edge
//   KEY2       in   asynchronous active-low reset
//   bus        slave modport of memseq_if (start/entry in, display out)
//   dbg_state  out  current FSM state encoding
module memseq_engine #(
    parameter int          N_LIGHTS   = 4,
    parameter int          SEQ_LEN    = 4,
    parameter int          N_LEVELS   = 9,
    parameter int          LIVES      = 3,
    parameter int          STEP_TICKS = 25_000_000,
    parameter int          GAP_TICKS  = 12_500_000,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic        clk50,
    input  logic        KEY2,
    memseq_if.slave     bus,
    output logic [2:0]  dbg_state
);
    localparam int LW   = $clog2(N_LIGHTS);
    localparam int IW   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int TMAX = (STEP_TICKS > GAP_TICKS) ? STEP_TICKS : GAP_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [IW-1:0] IDX_LAST   = IW'(SEQ_LEN - 1);
    localparam logic [TW-1:0] STEP_LAST  = TW'(STEP_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);
    localparam logic [7:0]    LEVEL_LAST = 8'(N_LEVELS - 1);
    localparam logic [2:0]    LIVES_INIT = 3'(LIVES);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GEN      = 3'd1;
    localparam logic [2:0] S_SHOW_ON  = 3'd2;
    localparam logic [2:0] S_SHOW_GAP = 3'd3;
    localparam logic [2:0] S_INPUT    = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]          state;
    logic [15:0]         lfsr;
    logic [LW-1:0]       seq [SEQ_LEN];
    logic [IW-1:0]       idx;
    logic [TW-1:0]       tcnt;
    logic [N_LIGHTS-1:0] lights_q;
    logic [7:0]          level_q;
    logic [3:0]          score_q;
    logic [2:0]          lives_q;
    logic                pass_q;
    logic                fail_q;
    logic                game_over_q;
    logic                won_q;

    logic                lfsr_fb;
    logic [N_LIGHTS-1:0] target;
    logic                entry_ok;

    // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10).
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // One-hot of the current step; used both for playback and for checking.
    // A non-one-hot entry can never equal it, so it is always a mismatch.
    always_comb begin
        target           = '0;
        target[seq[idx]] = 1'b1;
    end

    assign entry_ok = (bus.entry == target);

    always_ff @(posedge clk50 or negedge KEY2) begin
        if (!KEY2) begin
            state       <= S_IDLE;
            lfsr        <= SEED;
            for (int i = 0; i < SEQ_LEN; i++) seq[i] <= '0;
            idx         <= '0;
            tcnt        <= '0;
            lights_q    <= '0;
            level_q     <= '0;
            score_q     <= '0;
            lives_q     <= LIVES_INIT;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            game_over_q <= 1'b0;
            won_q       <= 1'b0;
        end else begin
            lfsr   <= {lfsr[14:0], lfsr_fb};
            pass_q <= 1'b0;
            fail_q <= 1'b0;
            // Lights are registered from the state, so they trail the
            // SHOW_ON state by one cycle with the same lit/dark durations.
            lights_q <= (state == S_SHOW_ON) ? target : '0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        level_q     <= '0;
                        score_q     <= '0;
                        idx         <= '0;
                        tcnt        <= '0;
                        lives_q     <= LIVES_INIT;
                        game_over_q <= 1'b0;
                        won_q       <= 1'b0;
                        state       <= S_GEN;
                    end
                end

                S_GEN: begin
                    seq[idx] <= lfsr[LW-1:0];
                    tcnt     <= '0;
                    if (idx == IDX_LAST) begin
                        idx   <= '0;
                        state <= S_SHOW_ON;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end

                S_SHOW_ON: begin
                    if (tcnt == STEP_LAST) begin
                        tcnt  <= '0;
                        state <= S_SHOW_GAP;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                S_SHOW_GAP: begin
                    if (tcnt == GAP_LAST) begin
                        tcnt <= '0;
                        if (idx == IDX_LAST) begin
                            idx   <= '0;
                            state <= S_INPUT;
                        end else begin
                            idx   <= idx + IW'(1);
                            state <= S_SHOW_ON;
                        end
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                S_INPUT: begin
                    if (bus.entry_valid) begin
                        if (entry_ok) begin
                            if (idx == IDX_LAST) begin
                                pass_q  <= 1'b1;
                                score_q <= (score_q == 4'hF) ? score_q : score_q + 4'd1;
                                idx     <= '0;
                                if (level_q == LEVEL_LAST) begin
                                    won_q <= 1'b1;
                                    state <= S_DONE;
                                end else begin
                                    level_q <= level_q + 8'd1;
                                    state   <= S_GEN;
                                end
                            end else begin
                                idx <= idx + IW'(1);
                            end
                        end else begin
                            fail_q  <= 1'b1;
                            lives_q <= lives_q - 3'd1;
                            idx     <= '0;
                            tcnt    <= '0;
                            // Last life lost ends the game; otherwise replay
                            // the stored sequence without regenerating it.
                            if (lives_q == 3'd1) begin
                                game_over_q <= 1'b1;
                                state       <= S_DONE;
                            end else begin
                                state <= S_SHOW_ON;
                            end
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.lights      = lights_q;
    assign bus.await_input = (state == S_INPUT);
    assign bus.level       = level_q;
    assign bus.score       = score_q;
    assign bus.lives_left  = lives_q;
    assign bus.pass_p      = pass_q;
    assign bus.fail_p      = fail_q;
    assign bus.game_over   = game_over_q;
    assign bus.won         = won_q;
    assign dbg_state       = state;
endmodule

// File: tb/tb_memseq_engine.sv
// tb_memseq_engine: self-checking bench for memseq_engine with a small game
// (4 lights, 4 steps, 2 levels, 2 lives, 3 cycles lit, 2 cycles dark).
module tb_memseq_engine;
    localparam int          NL   = 4;
    localparam int          SL   = 4;
    localparam int          NLV  = 2;
    localparam int          LV   = 2;
    localparam int          ST   = 3;
    localparam int          GP   = 2;
    localparam logic [15:0] SD   = 16'hACE1;
    localparam int          PLAY = SL * (ST + GP);

    localparam int PH_IDLE  = 0;
    localparam int PH_GEN   = 1;
    localparam int PH_PLAY  = 2;
    localparam int PH_INPUT = 3;
    localparam int PH_DONE  = 4;

    // ---------------- clock / reset ----------------
    logic       clk50 = 1'b0;
    logic       KEY2  = 1'b1;
    logic [2:0] dbg_state;

    always #5 clk50 = ~clk50;

    memseq_if #(.N_LIGHTS(NL)) bus ();

    memseq_engine #(
        .N_LIGHTS(NL), .SEQ_LEN(SL), .N_LEVELS(NLV), .LIVES(LV),
        .STEP_TICKS(ST), .GAP_TICKS(GP), .SEED(SD)
    ) dut (
        .clk50     (clk50),
        .KEY2      (KEY2),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          model_on = 1'b0;
    int          m_phase, m_age, m_pos, m_level, m_score, m_lives;
    bit          m_pass, m_fail, m_won, m_go;
    logic [15:0] m_lfsr;
    logic [1:0]  m_seq [SL];

    logic          smp_active, smp_start, smp_ev;
    logic [NL-1:0] smp_entry;

    always @(posedge clk50) begin
        smp_active <= KEY2;
        smp_start  <= bus.start;
        smp_ev     <= bus.entry_valid;
        smp_entry  <= bus.entry;
    end

    function automatic logic [NL-1:0] onehot(input logic [1:0] v);
        logic [NL-1:0] r;
        r    = '0;
        r[v] = 1'b1;
        return r;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE; m_age = 0; m_pos = 0;
        m_level = 0; m_score = 0; m_lives = LV;
        m_pass = 0; m_fail = 0; m_won = 0; m_go = 0;
        m_lfsr = SD;
        for (int i = 0; i < SL; i++) m_seq[i] = 2'd0;
    endtask

    task automatic model_step();
        logic [15:0] lf;
        lf     = m_lfsr;
        m_pass = 0;
        m_fail = 0;
        case (m_phase)
            PH_IDLE, PH_DONE: if (smp_start) begin
                m_level = 0; m_score = 0; m_lives = LV;
                m_won = 0; m_go = 0; m_pos = 0; m_age = 0;
                m_phase = PH_GEN;
            end
            PH_GEN: begin
                m_seq[m_age] = lf[1:0];
                if (m_age == SL - 1) begin m_phase = PH_PLAY; m_age = 0; end
                else m_age++;
            end
            PH_PLAY: begin
                m_age++;
                if (m_age == PLAY) begin m_phase = PH_INPUT; m_pos = 0; end
            end
            PH_INPUT: if (smp_ev) begin
                if (smp_entry == onehot(m_seq[m_pos])) begin
                    if (m_pos == SL - 1) begin
                        m_pass = 1; m_pos = 0;
                        if (m_score < 15) m_score++;
                        if (m_level == NLV - 1) begin m_won = 1; m_phase = PH_DONE; end
                        else begin m_level++; m_phase = PH_GEN; m_age = 0; end
                    end else begin
                        m_pos++;
                    end
                end else begin
                    m_fail = 1; m_pos = 0; m_lives--;
                    if (m_lives == 0) begin m_go = 1; m_phase = PH_DONE; end
                    else begin m_phase = PH_PLAY; m_age = 0; end
                end
            end
            default: ;
        endcase
        m_lfsr = lfsr_next(lf);
    endtask

    // Playback timeline: lights appear one cycle into the play phase, then each
    // step is lit for ST cycles followed by GP dark cycles.
    function automatic logic [NL-1:0] exp_lights();
        if (m_phase == PH_PLAY && m_age >= 1 && ((m_age - 1) % (ST + GP)) < ST)
            return onehot(m_seq[(m_age - 1) / (ST + GP)]);
        return '0;
    endfunction

    // Compare process: every falling edge once reset has been applied.
    initial begin
        forever begin
            @(negedge clk50);
            if (model_on) begin
                if (!KEY2) model_reset();
                else if (smp_active) model_step();
                check("lights",      bus.lights,      exp_lights());
                check("await_input", bus.await_input, (m_phase == PH_INPUT));
                check("level",       bus.level,       m_level);
                check("score",       bus.score,       m_score);
                check("lives_left",  bus.lives_left,  m_lives);
                check("pass_p",      bus.pass_p,      m_pass);
                check("fail_p",      bus.fail_p,      m_fail);
                check("game_over",   bus.game_over,   m_go);
                check("won",         bus.won,         m_won);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(negedge clk50) bus.start = 1'b1;
        @(negedge clk50) bus.start = 1'b0;
    endtask

    task automatic wait_await();
        for (int i = 0; i < 200; i++) begin
            if (bus.await_input === 1'b1) break;
            @(negedge clk50);
        end
        check("await_rise", bus.await_input, 1);
    endtask

    // Called on a falling edge; returns on the falling edge after the entry
    // was sampled.
    task automatic enter(input logic [NL-1:0] v);
        bus.entry_valid = 1'b1;
        bus.entry       = v;
        @(negedge clk50);
        bus.entry_valid = 1'b0;
        bus.entry       = '0;
    endtask

    task automatic first_light(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk50);
            if (bus.lights != '0) begin n = i; break; end
        end
    endtask

    // ---------------- directed scenarios ----------------
    int         n, lit, dark;
    logic [1:0] wrong;

    initial begin
        bus.start = 1'b0; bus.entry_valid = 1'b0; bus.entry = '0;
        #2 KEY2 = 1'b0;
        model_on = 1'b1;
        repeat (2) @(negedge clk50);
        #2 KEY2 = 1'b1;

        // Idle after reset.
        repeat (10) @(negedge clk50);
        check("idle_lights", bus.lights, 0);
        check("idle_await",  bus.await_input, 0);
        check("idle_level",  bus.level, 0);
        check("idle_score",  bus.score, 0);
        check("idle_lives",  bus.lives_left, 2);

        // Game 1: playback timing.
        pulse_start();
        first_light(n);
        check("first_light_delay", n, 5);
        lit = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk50);
            if (bus.lights == '0) break;
            lit++;
        end
        dark = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk50);
            if (bus.lights != '0) break;
            dark++;
        end
        check("lit_cycles",  lit, 3);
        check("dark_cycles", dark, 2);

        // Level 0: back-to-back correct entries.
        wait_await();
        for (int k = 0; k < SL; k++) begin
            bus.entry_valid = 1'b1;
            bus.entry       = onehot(m_seq[k]);
            @(negedge clk50);
        end
        bus.entry_valid = 1'b0;
        bus.entry       = '0;
        check("l0_pass_p", bus.pass_p, 1);
        check("l0_score",  bus.score, 1);
        check("l0_level",  bus.level, 1);
        check("l0_await",  bus.await_input, 0);
        @(negedge clk50);
        check("l0_pass_once", bus.pass_p, 0);

        // Level 1: spaced correct entries, winning the game.
        wait_await();
        for (int k = 0; k < SL; k++) begin
            enter(onehot(m_seq[k]));
            if (k < SL - 1) @(negedge clk50);
        end
        check("win_won",   bus.won, 1);
        check("win_score", bus.score, 2);
        check("win_await", bus.await_input, 0);

        // Game 2: wrong entry at step 2, replay, then non-one-hot entry.
        pulse_start();
        check("g2_lives", bus.lives_left, 2);
        check("g2_score", bus.score, 0);
        check("g2_won",   bus.won, 0);
        wait_await();
        enter(onehot(m_seq[0]));
        enter(onehot(m_seq[1]));
        wrong = m_seq[2] + 2'd1;
        enter(onehot(wrong));
        check("wrong_fail_p", bus.fail_p, 1);
        check("wrong_lives",  bus.lives_left, 1);
        check("wrong_await",  bus.await_input, 0);
        wait_await();
        enter(4'b0011);
        check("multi_fail_p",  bus.fail_p, 1);
        check("multi_lives",   bus.lives_left, 0);
        check("multi_gameover", bus.game_over, 1);
        @(negedge clk50);
        enter(onehot(m_seq[0]));
        check("done_ignore_fail", bus.fail_p, 0);
        check("done_ignore_go",   bus.game_over, 1);

        // Restart from game over, then poke entry_valid during playback.
        pulse_start();
        check("rs_lives",    bus.lives_left, 2);
        check("rs_score",    bus.score, 0);
        check("rs_gameover", bus.game_over, 0);
        first_light(n);
        check("rs_first_light", n, 5);
        enter(onehot(m_seq[0]));
        check("show_ignore_lives", bus.lives_left, 2);
        check("show_ignore_fail",  bus.fail_p, 0);
        check("show_ignore_pass",  bus.pass_p, 0);

        // Asynchronous reset in the middle of playback.
        repeat (3) @(negedge clk50);
        #2 KEY2 = 1'b0;
        #1;
        check("async_lights", bus.lights, 0);
        check("async_await",  bus.await_input, 0);
        check("async_level",  bus.level, 0);
        check("async_lives",  bus.lives_left, 2);
        check("async_state",  dbg_state, 0);
        repeat (2) @(negedge clk50);
        #2 KEY2 = 1'b1;
        @(negedge clk50);

        // Normal play after reset release.
        pulse_start();
        first_light(n);
        check("post_rst_first_light", n, 5);
        wait_await();
        for (int k = 0; k < SL; k++) enter(onehot(m_seq[k]));
        check("post_rst_pass",  bus.pass_p, 1);
        check("post_rst_score", bus.score, 1);
        check("post_rst_level", bus.level, 1);
        repeat (5) @(negedge clk50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/memseq_engine.md
# memseq_engine

Parametrised memory-sequence game engine: generates a pseudo-random light sequence per level, plays it out on one-hot lights, then checks the player's entries step by step. Replaces the hard-coded nine-sequence block with configurable light count, sequence length, level count, display timing and lives, and adds wrong-entry detection and a game-over condition. It sits between debounced KEY/SW inputs and the LEDR/LEDG/HEX display drivers.

## Interface
- N_LIGHTS, 4: number of lights/entry buttons; must be 2, 4 or 8.
- SEQ_LEN, 4: steps per sequence, 1..16.
- N_LEVELS, 9: levels to win, 1..255.
- LIVES, 3: wrong sequences tolerated before game over, 1..7.
- STEP_TICKS, 25_000_000: clk50 cycles each step is lit.
- GAP_TICKS, 12_500_000: clk50 cycles dark between steps.
- SEED, 16'hACE1: LFSR reset value, non-zero.
- clk50  in  1  system clock; all logic on its rising edge.
- KEY2  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse: begin a new game.
- entry_valid  in  1  one-cycle pulse: entry is valid.
- entry  in  N_LIGHTS  player entry, expected one-hot.
- lights  out  N_LIGHTS  one-hot playback; 0 when not showing.
- await_input  out  1  high while entries are accepted (LEDG).
- level  out  8  current level, 0-based.
- score  out  4  completed levels, saturates at 15.
- lives_left  out  3  remaining lives.
- pass_p  out  1  one-cycle pulse: level completed.
- fail_p  out  1  one-cycle pulse: wrong entry.
- game_over  out  1  high in DONE after losing all lives.
- won  out  1  high in DONE after the last level.

## Operation
- States: IDLE, GEN, SHOW_ON, SHOW_GAP, INPUT, DONE.
- Reset (KEY2 low, asynchronous): state IDLE, LFSR = SEED, lights 0, await_input 0, level 0, score 0, lives_left = LIVES, pass_p/fail_p/game_over/won 0, step index 0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle after reset, including in IDLE.
- IDLE/DONE + start: clear level, score and step index; lives_left = LIVES; game_over = won = 0; go to GEN. start in any other state is ignored.
- GEN: SEQ_LEN cycles. Each cycle stores LFSR[log2(N_LIGHTS)-1:0] into seq[idx], idx increments. Then idx = 0 and the state goes to SHOW_ON.
- SHOW_ON: lights = onehot(seq[idx]) for STEP_TICKS cycles, then SHOW_GAP.
- SHOW_GAP: lights = 0 for GAP_TICKS cycles. If idx is not the last step, idx increments and the state returns to SHOW_ON. After the last step, idx = 0 and the state goes to INPUT.
- INPUT: await_input = 1. Each entry_valid compares entry against onehot(seq[idx]); a non-one-hot entry is a mismatch.
  - Match, not last step: idx increments.
  - Match on last step: pass_p pulses, score increments (saturating), idx = 0. If level = N_LEVELS-1, go to DONE with won = 1; otherwise level increments and the state goes to GEN.
  - Mismatch: fail_p pulses, lives_left decrements, idx = 0. If the decremented value is 0, go to DONE with game_over = 1; otherwise go to SHOW_ON and replay the same sequence (no regeneration).
- entry_valid outside INPUT is ignored with no side effects.
- The DONE outputs (won, game_over, level, score) are held until start or reset.

## Timing
- start sampled at edge t: GEN occupies t+1..t+SEQ_LEN, and lights become non-zero from edge t+SEQ_LEN+1.
- One full playback lasts SEQ_LEN*(STEP_TICKS+GAP_TICKS) cycles after GEN; await_input rises on the edge that ends the last gap.
- entry_valid sampled at edge k: pass_p/fail_p, counter updates and the state change all become visible after edge k, lasting exactly one cycle. await_input is low from that edge if the state leaves INPUT.
- Back-to-back entry_valid pulses on consecutive cycles are each evaluated.
- Reset asserted mid-game clears everything immediately, without waiting for a clock edge; the first state after release is IDLE.

## Test plan
All scenarios use N_LIGHTS=4, SEQ_LEN=4, N_LEVELS=2, LIVES=2, STEP_TICKS=3, GAP_TICKS=2.
- Reset then idle 10 cycles: lights=0, await_input=0, level=0, score=0, lives_left=2; start pulse → lights non-zero exactly 5 cycles later, each step lit 3 cycles, dark 2 cycles.
- Record the 4 played steps and enter them correctly → pass_p one cycle, score=1, level=1, a new GEN follows; repeat on level 1 → won=1, score=2, await_input=0.
- On level 0, enter the wrong light at step 2 → fail_p one cycle, lives_left=1, the identical 4-step sequence is replayed, then await_input=1.
- Fail twice → game_over=1, lives_left=0; entry_valid is then ignored; start → lives_left=2, score=0, game_over=0, GEN begins.
- entry=4'b0011 with entry_valid in INPUT → treated as a mismatch, fail_p asserted; entry_valid during SHOW_ON → no counter or state change.
- Drop KEY2 mid-playback between clock edges → all outputs at their reset values immediately; start after release works normally.
